// File: rtl/darkroom_spi_rx.sv
// SPI mode-0 slave receiver: oversamples sck/mosi/ss_n on the system clock,
// assembles MSB-first words into a show-ahead FIFO and reports frame status.
module darkroom_spi_rx #(
  parameter int WORD_BITS  = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sck_i,
  input  logic                 mosi_i,
  input  logic                 ss_n_i,
  output logic [WORD_BITS-1:0] word_o,
  output logic                 word_valid_o,
  input  logic                 word_ready_i,
  output logic                 word_first_o,
  output logic                 frame_done_o,
  output logic [7:0]           frame_words_o,
  output logic                 short_word_o,
  output logic                 overrun_o,
  input  logic                 overrun_clr_i
);

  localparam int BIT_CNT_W = $clog2(WORD_BITS + 1);
  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int OCC_W     = PTR_W + 1;

  localparam logic [BIT_CNT_W-1:0] BITS_FULL = BIT_CNT_W'(WORD_BITS);
  localparam logic [OCC_W-1:0]     OCC_FULL  = OCC_W'(FIFO_DEPTH);

  typedef enum logic {
    ST_IDLE,
    ST_FRAME
  } rx_state_e;

  // ---------------------------------------------------------------------------
  // Input synchronizers, history registers and registered edge events
  // ---------------------------------------------------------------------------
  logic [1:0] sck_sync, mosi_sync, ss_sync;
  logic       sck_hist, mosi_hist, ss_hist;
  logic [2:0] pipe_vld;
  logic       sck_rise, ss_fall, ss_rise;

  // pipe_vld tracks how far real pin data has travelled since reset; edges
  // against reset values are not real and must not start a frame mid-word.
  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync  <= 2'b00;
      mosi_sync <= 2'b00;
      ss_sync   <= 2'b11;
      sck_hist  <= 1'b0;
      mosi_hist <= 1'b0;
      ss_hist   <= 1'b1;
      pipe_vld  <= 3'b000;
      sck_rise  <= 1'b0;
      ss_fall   <= 1'b0;
      ss_rise   <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[0], sck_i};
      mosi_sync <= {mosi_sync[0], mosi_i};
      ss_sync   <= {ss_sync[0], ss_n_i};
      sck_hist  <= sck_sync[1];
      mosi_hist <= mosi_sync[1];
      ss_hist   <= ss_sync[1];
      pipe_vld  <= {pipe_vld[1:0], 1'b1};
      sck_rise  <= pipe_vld[2] &  sck_sync[1] & ~sck_hist;
      ss_fall   <= pipe_vld[2] & ~ss_sync[1]  &  ss_hist;
      ss_rise   <= pipe_vld[2] &  ss_sync[1]  & ~ss_hist;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame state, deserializer and frame status
  // ---------------------------------------------------------------------------
  rx_state_e              state;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic [WORD_BITS-1:0]   shift_q;
  logic [7:0]             frame_cnt;
  logic [7:0]             frame_cnt_inc;
  logic                   first_pending;
  logic                   word_push;

  assign word_push     = (bit_cnt == BITS_FULL);
  assign frame_cnt_inc = (frame_cnt == 8'hFF) ? 8'hFF : frame_cnt + 8'd1;

  // A word completing in the same cycle as ss_rise still counts toward the
  // frame total and is not reported as a short word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      bit_cnt       <= '0;
      shift_q       <= '0;
      frame_cnt     <= '0;
      first_pending <= 1'b0;
      frame_done_o  <= 1'b0;
      short_word_o  <= 1'b0;
      frame_words_o <= '0;
    end else begin
      frame_done_o <= 1'b0;
      short_word_o <= 1'b0;

      if (word_push) begin
        bit_cnt       <= '0;
        frame_cnt     <= frame_cnt_inc;
        first_pending <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (ss_fall) begin
            state         <= ST_FRAME;
            bit_cnt       <= '0;
            shift_q       <= '0;
            frame_cnt     <= '0;
            first_pending <= 1'b1;
          end
        end
        ST_FRAME: begin
          if (ss_rise) begin
            state         <= ST_IDLE;
            bit_cnt       <= '0;
            frame_done_o  <= 1'b1;
            frame_words_o <= word_push ? frame_cnt_inc : frame_cnt;
            short_word_o  <= (bit_cnt != '0) && !word_push;
          end else if (sck_rise) begin
            shift_q <= {shift_q[WORD_BITS-2:0], mosi_hist};
            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Show-ahead word FIFO
  // ---------------------------------------------------------------------------
  logic [WORD_BITS-1:0] mem_word  [FIFO_DEPTH];
  logic                 mem_first [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [OCC_W-1:0]     occ;
  logic                 fifo_full, do_pop, do_push;

  assign fifo_full    = (occ == OCC_FULL);
  assign word_valid_o = (occ != '0);
  assign do_pop       = word_valid_o & word_ready_i;
  assign do_push      = word_push & (~fifo_full | do_pop);

  // Outputs are forced to zero while empty so the unreset storage never shows.
  assign word_o       = word_valid_o ? mem_word[rd_ptr]  : '0;
  assign word_first_o = word_valid_o ? mem_first[rd_ptr] : 1'b0;

  // NOTE: the storage array is deliberately not reset; occupancy and pointers
  // define which entries are meaningful, and the array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_word[wr_ptr]  <= shift_q;
      mem_first[wr_ptr] <= first_pending;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Set has priority over a same-cycle clear so no drop goes unreported.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_o <= 1'b0;
    end else if (word_push & fifo_full & ~do_pop) begin
      overrun_o <= 1'b1;
    end else if (overrun_clr_i) begin
      overrun_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_darkroom_spi_rx.sv
// Scoreboard bench for darkroom_spi_rx: SPI master stimulus, expected words and
// frame reports queued by a frame-level model, compared by a separate monitor.
`timescale 1ns/1ps
module tb_darkroom_spi_rx;

  localparam int WB   = 32;
  localparam int HALF = 4;

  typedef logic [31:0] wlist_t[$];
  typedef struct {
    logic [31:0] w;
    logic        first;
  } word_exp_t;
  typedef struct {
    int unsigned n;
    logic        short_w;
  } frame_exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          sck, mosi, ss_n;
  logic          word_ready, overrun_clr;
  logic [WB-1:0] word;
  logic          word_valid, word_first, frame_done, short_word, overrun;
  logic [7:0]    frame_words;

  darkroom_spi_rx #(.WORD_BITS(WB), .FIFO_DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .sck_i         (sck),
    .mosi_i        (mosi),
    .ss_n_i        (ss_n),
    .word_o        (word),
    .word_valid_o  (word_valid),
    .word_ready_i  (word_ready),
    .word_first_o  (word_first),
    .frame_done_o  (frame_done),
    .frame_words_o (frame_words),
    .short_word_o  (short_word),
    .overrun_o     (overrun),
    .overrun_clr_i (overrun_clr)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int last_rise_cyc = 0;
  int ss_rise_cyc   = 0;
  int ready_mode    = 1;  // 0 low, 1 high, 2 random, 3 driven by stimulus

  word_exp_t  word_q[$];
  frame_exp_t frame_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Ready driver: changes just after the active edge, stable at the monitor.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       word_ready = 1'b0;
      1:       word_ready = 1'b1;
      2:       word_ready = 1'($urandom_range(0, 1));
      default: ;
    endcase
  end

  // Monitor: compares every accepted word and every frame report.
  always @(negedge clk) begin
    if (!rst) begin
      if (word_valid && word_ready) begin
        check("word_expected", 32'(word_q.size() > 0), 32'd1);
        if (word_q.size() > 0) begin
          word_exp_t e;
          e = word_q.pop_front();
          check("word_data", word, e.w);
          check("word_first", 32'(word_first), 32'(e.first));
        end
      end
      if (frame_done) begin
        check("frame_expected", 32'(frame_q.size() > 0), 32'd1);
        check("frame_done_latency", 32'(cyc - ss_rise_cyc), 32'd4);
        if (frame_q.size() > 0) begin
          frame_exp_t f;
          f = frame_q.pop_front();
          check("frame_words", 32'(frame_words), 32'(f.n));
          check("short_word", 32'(short_word), 32'(f.short_w));
        end
      end else if (short_word) begin
        check("short_without_done", 32'(frame_done), 32'd1);
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends the top nbits of val MSB first; optionally pops once in the push cycle.
  task automatic spi_bits(logic [31:0] val, int nbits, bit pop_at_push);
    for (int i = 0; i < nbits; i++) begin
      sck  = 1'b0;
      mosi = val[31-i];
      tick(HALF);
      sck = 1'b1;
      last_rise_cyc = cyc;
      if (pop_at_push && i == nbits - 1) begin
        tick(4);
        word_ready = 1'b1;
        tick(1);
        word_ready = 1'b0;
      end else begin
        tick(HALF);
      end
    end
  endtask

  task automatic send_frame(wlist_t words, int partial_bits, logic [31:0] partial_val,
                            bit pop_last);
    ss_n = 1'b0;
    tick(HALF);
    foreach (words[i]) spi_bits(words[i], 32, pop_last && (i == words.size() - 1));
    if (partial_bits > 0) spi_bits(partial_val, partial_bits, 1'b0);
    sck = 1'b0;
    tick(HALF);
    ss_n = 1'b1;
    ss_rise_cyc = cyc;
    tick(8);
  endtask

  // Frame-level model: which words land in the FIFO and what the frame reports.
  task automatic expect_frame(wlist_t words, int partial_bits, int keep);
    frame_exp_t f;
    for (int i = 0; i < words.size() && i < keep; i++) begin
      word_exp_t e;
      e.w     = words[i];
      e.first = (i == 0);
      word_q.push_back(e);
    end
    f.n       = (words.size() > 255) ? 255 : words.size();
    f.short_w = (partial_bits != 0);
    frame_q.push_back(f);
  endtask

  task automatic wait_drain(string name, int budget);
    for (int k = 0; k < budget && word_q.size() > 0; k++) tick(1);
    check(name, 32'(word_q.size()), 32'd0);
  endtask

  task automatic check_reset_state(string tag);
    check({tag, "_valid"}, 32'(word_valid), 32'd0);
    check({tag, "_word"}, word, 32'd0);
    check({tag, "_first"}, 32'(word_first), 32'd0);
    check({tag, "_done"}, 32'(frame_done), 32'd0);
    check({tag, "_frame_words"}, 32'(frame_words), 32'd0);
    check({tag, "_short"}, 32'(short_word), 32'd0);
    check({tag, "_overrun"}, 32'(overrun), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    wlist_t w;
    rst = 1'b1; sck = 1'b0; mosi = 1'b0; ss_n = 1'b1;
    word_ready = 1'b0; overrun_clr = 1'b0;
    tick(3);
    check_reset_state("reset");
    rst = 1'b0;
    tick(5);

    // Single word, ready held high; also measures sck-to-valid latency.
    ready_mode = 1;
    w.delete(); w.push_back(32'hDEADBEEF);
    expect_frame(w, 0, 1);
    fork
      send_frame(w, 0, 32'd0, 1'b0);
      begin
        int lat = -1;
        for (int k = 0; k < 600; k++) begin
          @(posedge clk); #1;
          if (word_valid) begin
            lat = cyc - last_rise_cyc;
            break;
          end
        end
        check("word_latency", 32'(lat), 32'd5);
      end
    join
    tick(10);
    check("frame_words_hold", 32'(frame_words), 32'd1);

    // Three-word frame.
    w.delete();
    w.push_back(32'h00000001); w.push_back(32'h80000000); w.push_back(32'hA5A5A5A5);
    expect_frame(w, 0, 3);
    send_frame(w, 0, 32'd0, 1'b0);
    wait_drain("drain_three", 200);

    // Five words into a stalled 4-deep FIFO: fifth dropped, overrun set.
    ready_mode = 0;
    tick(2);
    w.delete();
    for (int i = 0; i < 5; i++) w.push_back($urandom());
    expect_frame(w, 0, 4);
    send_frame(w, 0, 32'd0, 1'b0);
    check("overrun_set", 32'(overrun), 32'd1);
    check("full_valid", 32'(word_valid), 32'd1);
    overrun_clr = 1'b1;
    tick(1);
    overrun_clr = 1'b0;
    check("overrun_cleared", 32'(overrun), 32'd0);
    ready_mode = 1;
    wait_drain("drain_overrun", 200);

    // Full FIFO with a pop exactly in the push cycle: no overrun, order kept.
    ready_mode = 0;
    tick(2);
    w.delete();
    for (int i = 0; i < 4; i++) w.push_back($urandom());
    expect_frame(w, 0, 4);
    send_frame(w, 0, 32'd0, 1'b0);
    ready_mode = 3;
    word_ready = 1'b0;
    w.delete(); w.push_back($urandom());
    expect_frame(w, 0, 1);
    send_frame(w, 0, 32'd0, 1'b1);
    check("simul_pop_overrun", 32'(overrun), 32'd0);
    check("simul_pop_valid", 32'(word_valid), 32'd1);
    ready_mode = 1;
    wait_drain("drain_simul", 200);

    // 12-bit partial frame, then sck activity with ss_n high.
    w.delete();
    expect_frame(w, 12, 0);
    send_frame(w, 12, $urandom(), 1'b0);
    for (int i = 0; i < 40; i++) begin
      mosi = 1'($urandom_range(0, 1));
      sck = 1'b1; tick(HALF);
      sck = 1'b0; tick(HALF);
    end
    tick(8);
    check("idle_sck_no_word", 32'(word_valid), 32'd0);

    // Reset after 20 bits while ss_n stays low; that frame must be ignored.
    ss_n = 1'b0;
    tick(HALF);
    spi_bits($urandom(), 20, 1'b0);
    sck = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(2);
    check_reset_state("midword_reset");
    rst = 1'b0;
    tick(3);
    spi_bits($urandom(), 12, 1'b0);
    sck = 1'b0;
    tick(HALF);
    ss_n = 1'b1;
    tick(12);
    check("after_reset_no_word", 32'(word_valid), 32'd0);
    w.delete(); w.push_back(32'h12345678);
    expect_frame(w, 0, 1);
    send_frame(w, 0, 32'd0, 1'b0);
    wait_drain("drain_after_reset", 200);

    // Random frames with random consumer back-pressure.
    ready_mode = 2;
    for (int f = 0; f < 12; f++) begin
      int nw, pb;
      nw = $urandom_range(1, 3);
      pb = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 31) : 0;
      w.delete();
      for (int i = 0; i < nw; i++) w.push_back($urandom());
      expect_frame(w, pb, nw);
      send_frame(w, pb, $urandom(), 1'b0);
    end
    ready_mode = 1;
    wait_drain("drain_random", 400);
    check("random_overrun", 32'(overrun), 32'd0);

    tick(10);
    check("frames_outstanding", 32'(frame_q.size()), 32'd0);
    check("words_outstanding", 32'(word_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
